// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants and types used by the register file.
//   XLEN      - architectural data width
//   REG_AW    - register address width
//   NUM_REGS  - number of architectural registers
//   reg_addr_t / word_t - register address and data word types
//   REG_ZERO  - address of the hardwired-zero register x0
package rv32i_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // True when an address selects a register that has storage behind it.
  function automatic logic reg_addr_valid(input logic [REG_AW-1:0] addr,
                                          input int unsigned       nreg);
    return (addr != REG_ZERO) && (32'(addr) < nreg);
  endfunction

endpackage : rv32i_pkg

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port of the register file.
//   rst_n    - async active-low reset; forces the output to zero while low
//   ra_i     - read address
//   regs_i   - view of all registers, entry 0 is the constant zero of x0
//   we_i     - write enable of the write port (for write-through bypass)
//   waddr_i  - write address of the write port
//   wdata_i  - write data of the write port
//   rd_o     - read data
module regfile_read_port
  import rv32i_pkg::*;
#(
  parameter int unsigned N    = XLEN,
  parameter int unsigned NREG = NUM_REGS,
  parameter int unsigned AW   = REG_AW
) (
  input  logic                      rst_n,
  input  logic [AW-1:0]             ra_i,
  input  logic [NREG-1:0][N-1:0]    regs_i,
  input  logic                      we_i,
  input  logic [AW-1:0]             waddr_i,
  input  logic [N-1:0]              wdata_i,
  output logic [N-1:0]              rd_o
);

  logic addr_ok;
  logic bypass_hit;

  // Address qualification only looks at addresses, never at storage contents,
  // so the bypass compare stays off the storage read path.
  assign addr_ok    = (ra_i != AW'(0)) && (32'(ra_i) < NREG);
  assign bypass_hit = we_i && (waddr_i == ra_i);

  // Read mux: reset, x0 / out-of-range, write-through bypass, then storage.
  always_comb begin
    rd_o = '0;
    if (rst_n && addr_ok) begin
      if (bypass_hit) begin
        rd_o = wdata_i;
      end else begin
        rd_o = regs_i[ra_i];
      end
    end
  end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// register_file: RV32I architectural register file, one write port fed by
// writeback and two combinational read ports feeding decode, with
// write-through bypass so a register written in WB is readable in ID in the
// same cycle. x0 reads as zero and ignores writes.
//   clk    - pipeline clock, storage updates on rising edge
//   rst_n  - asynchronous active-low reset, clears all registers at once
//   we     - write enable from WB
//   waddr  - destination register
//   wdata  - writeback result, stored verbatim
//   ra1    - read address port 1
//   ra2    - read address port 2
//   rd1    - read data port 1 (combinational)
//   rd2    - read data port 2 (combinational)
module register_file
  import rv32i_pkg::*;
#(
  parameter int unsigned N    = XLEN,
  parameter int unsigned NREG = NUM_REGS,
  parameter int unsigned AW   = REG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2
);

  // Storage for x1..x(NREG-1) only; x0 has no flops.
  logic [NREG-1:1][N-1:0] regs_q;
  logic [NREG-1:1][N-1:0] regs_d;
  logic [NREG-1:0][N-1:0] regs_view;
  logic                   wr_en;

  // Writes to x0 or beyond NREG are dropped here.
  assign wr_en = we && (waddr != AW'(0)) && (32'(waddr) < NREG);

  // Next-state: only the addressed register takes wdata.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (wr_en && (waddr == AW'(i))) begin
        regs_d[i] = wdata;
      end
    end
  end

  // Flop array with async clear; not a RAM candidate because of the reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read view with a constant zero slot standing in for x0.
  assign regs_view = {regs_q, {N{1'b0}}};

  regfile_read_port #(
    .N    (N),
    .NREG (NREG),
    .AW   (AW)
  ) u_read_port1 (
    .rst_n   (rst_n),
    .ra_i    (ra1),
    .regs_i  (regs_view),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rd_o    (rd1)
  );

  regfile_read_port #(
    .N    (N),
    .NREG (NREG),
    .AW   (AW)
  ) u_read_port2 (
    .rst_n   (rst_n),
    .ra_i    (ra2),
    .regs_i  (regs_view),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rd_o    (rd2)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// tb_register_file: directed scenarios plus randomized traffic for
// register_file, checked against an array-based architectural model.
module tb_register_file;

  localparam int unsigned N    = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [N-1:0]  rd1;
  logic [N-1:0]  rd2;

  int total = 0;
  int bad   = 0;

  // Architectural state: one word per register, x0 entry never written.
  logic [N-1:0] model [NREG];

  always #5 clk = ~clk;

  register_file #(
    .N    (N),
    .NREG (NREG),
    .AW   (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] expect_rd(input logic [AW-1:0] ra);
    if (rst_n !== 1'b1)          return '0;
    if (ra == 0)                 return '0;
    if (we && (waddr == ra))     return wdata;
    return model[ra];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < int'(NREG); i++) model[i] = '0;
  endfunction

  // One cycle: drive at negedge, check both ports mid-cycle, commit at posedge.
  task automatic step(input logic w, input logic [AW-1:0] wa, input logic [N-1:0] wd,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2, input string tag);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; ra1 = a1; ra2 = a2;
    #1;
    chk({tag, "/rd1"}, rd1, expect_rd(a1));
    chk({tag, "/rd2"}, rd2, expect_rd(a2));
    @(posedge clk);
    if (rst_n && we && (waddr != 0)) model[waddr] = wdata;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; ra1 = '0; ra2 = '0;
    model_clear();

    // Reset held three cycles, outputs zero throughout.
    repeat (3) begin
      @(negedge clk);
      ra1 = 5'd5; ra2 = 5'd31;
      #1;
      chk("in_reset/rd1", rd1, 32'h0);
      chk("in_reset/rd2", rd2, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, "after_reset");

    // Write then read, with same-cycle bypass on port 2.
    step(1'b1, 5'd7, 32'hDEADBEEF, 5'd0, 5'd7, "wr7_bypass");
    step(1'b0, 5'd0, 32'h0,        5'd7, 5'd1, "rd7");
    @(negedge clk); #1;
    chk("rd7_const", rd1, 32'hDEADBEEF);

    // x0 immutability.
    step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "x0_write");
    step(1'b0, 5'd0, 32'h0,        5'd0, 5'd0, "x0_after");

    // Both ports on the same bypassed register.
    step(1'b1, 5'd3, 32'h11111111, 5'd3, 5'd3, "x3_first");
    step(1'b1, 5'd3, 32'h22222222, 5'd3, 5'd3, "x3_bypass");
    step(1'b0, 5'd0, 32'h0,        5'd3, 5'd3, "x3_stored");

    // Async reset between edges.
    step(1'b1, 5'd9, 32'h12345678, 5'd0, 5'd0, "x9_write");
    @(negedge clk);
    we = 1'b0; ra1 = 5'd9; ra2 = 5'd3;
    #1;
    chk("pre_rst/rd1", rd1, 32'h12345678);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst/rd1", rd1, 32'h0);
    chk("async_rst/rd2", rd2, 32'h0);
    model_clear();
    @(posedge clk);
    // Write presented at the edge where reset is still low must be dropped.
    @(negedge clk);
    we = 1'b1; waddr = 5'd4; wdata = 32'hAAAA5555; ra1 = 5'd4; ra2 = 5'd9;
    #1;
    chk("rst_low_bypass/rd1", rd1, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd4, "post_rst");

    // Sweep: x[i] = i*0x01010101, then read pairs (i, 32-i).
    for (int i = 1; i < int'(NREG); i++) begin
      step(1'b1, AW'(i), N'(i) * 32'h01010101, 5'd0, AW'(i), "sweep_wr");
    end
    for (int i = 1; i <= int'(NREG); i++) begin
      step(1'b0, 5'd0, 32'h0, AW'(i % 32), AW'(32 - i), "sweep_rd");
    end
    @(negedge clk);
    we = 1'b0; ra1 = 5'd17; ra2 = 5'd0;
    #1;
    chk("sweep_x17_const", rd1, 32'h11111111);
    chk("sweep_x0_const",  rd2, 32'h0);

    // Randomized traffic, biased toward address collisions.
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] wa, a1, a2;
      wa = AW'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), wa, $urandom(), a1, a2, "rand");
    end

    // Final storage readback of every register.
    for (int i = 0; i < int'(NREG); i++) begin
      step(1'b0, 5'd0, 32'h0, AW'(i), AW'(31 - i), "final");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_register_file
